ovl_fifo_index_multi: RTL

Multi-channel FIFO occupancy checker for the OVL library. It generalises the single-FIFO index check to `CHANNELS` independent FIFOs with multi-entry push/pop per cycle. It also adds per-channel full/empty status, an end-of-test drain check, sticky error capture and first-error identification. It sits beside the DUT's FIFO bank, samples push/pop counts every clock, and raises registered one-cycle fire pulses on overflow, underflow, illegal simultaneous push/pop and non-empty-at-drain.

---
 rtl/ovl_fifo_index_multi.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ovl_fifo_index_multi.sv
// Multi-channel FIFO occupancy checker: tracks per-channel fill level and flags overflow,
// underflow, illegal push/pop and non-empty-at-drain. Optional high-water mark: OVL_FIFO_INDEX_HWM_EN.
module ovl_fifo_index_multi #(
    parameter int CHANNELS              = 4,
    parameter int DEPTH                 = 16,
    parameter int PUSH_WIDTH            = 2,
    parameter int POP_WIDTH             = 2,
    parameter int SIMULTANEOUS_PUSH_POP = 1,
    localparam int CNT_WIDTH            = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [CHANNELS*PUSH_WIDTH-1:0]  push,
    input  logic [CHANNELS*POP_WIDTH-1:0]   pop,
    input  logic                            check_empty,
    input  logic                            clear_err,
    output logic [CHANNELS*CNT_WIDTH-1:0]   cnt,
    output logic [CHANNELS-1:0]             full,
    output logic [CHANNELS-1:0]             empty,
    output logic [CHANNELS-1:0]             fire_overflow,
    output logic [CHANNELS-1:0]             fire_underflow,
    output logic [CHANNELS-1:0]             fire_push_pop,
    output logic [CHANNELS-1:0]             fire_not_empty,
    output logic [CHANNELS-1:0]             err_sticky,
    output logic                            first_err_valid,
    output logic [4:0]                      first_err_chan,
    output logic [2:0]                      first_err_code
`ifdef OVL_FIFO_INDEX_HWM_EN
    ,
    output logic [CHANNELS*CNT_WIDTH-1:0]   hwm
`endif
);

    localparam int MAX_W = (PUSH_WIDTH > POP_WIDTH) ? PUSH_WIDTH : POP_WIDTH;
    localparam int AW    = CNT_WIDTH + MAX_W + 1;

    logic [CNT_WIDTH-1:0] cnt_q    [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_next [CHANNELS];
    logic [CHANNELS-1:0]  ev_ov;
    logic [CHANNELS-1:0]  ev_un;
    logic [CHANNELS-1:0]  ev_pp;
    logic [CHANNELS-1:0]  ev_ne;
    logic [CHANNELS-1:0]  ev_any;
    logic                 sel_any;
    logic [4:0]           sel_chan;
    logic [2:0]           sel_code;

    // Overflow is tested as sum > DEPTH + pop so an underflowing sum - pop never wraps into it.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            logic [AW-1:0] sum;
            logic [AW-1:0] pv;
            logic          both;
            sum  = AW'(cnt_q[i]) + AW'(push[i*PUSH_WIDTH +: PUSH_WIDTH]);
            pv   = AW'(pop[i*POP_WIDTH +: POP_WIDTH]);
            both = (push[i*PUSH_WIDTH +: PUSH_WIDTH] != '0) && (pv != '0);
            ev_pp[i]    = 1'b0;
            ev_ov[i]    = 1'b0;
            ev_un[i]    = 1'b0;
            cnt_next[i] = cnt_q[i];
            if (both && (SIMULTANEOUS_PUSH_POP == 0)) begin
                ev_pp[i] = 1'b1;
            end else if (sum > AW'(DEPTH) + pv) begin
                ev_ov[i] = 1'b1;
            end else if (sum < pv) begin
                ev_un[i] = 1'b1;
            end else begin
                cnt_next[i] = CNT_WIDTH'(sum - pv);
            end
            ev_ne[i]  = check_empty && (cnt_q[i] != '0);
            ev_any[i] = ev_ov[i] | ev_un[i] | ev_pp[i] | ev_ne[i];
        end
    end

    // Scan from the top down so the lowest erroring channel is the one left selected.
    always_comb begin
        sel_any  = 1'b0;
        sel_chan = '0;
        sel_code = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ev_any[i]) begin
                sel_any  = 1'b1;
                sel_chan = 5'(i);
                if (ev_ov[i])      sel_code = 3'd1;
                else if (ev_un[i]) sel_code = 3'd2;
                else if (ev_pp[i]) sel_code = 3'd3;
                else               sel_code = 3'd4;
            end
        end
    end

`ifdef OVL_FIFO_INDEX_HWM_EN
    logic [CNT_WIDTH-1:0] hwm_q [CHANNELS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) hwm_q[i] <= '0;
        end else if (enable) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!(ev_ov[i] || ev_un[i] || ev_pp[i]) && (cnt_next[i] > hwm_q[i]))
                    hwm_q[i] <= cnt_next[i];
            end
        end
    end

    always_comb begin
        hwm = '0;
        for (int i = 0; i < CHANNELS; i++) hwm[i*CNT_WIDTH +: CNT_WIDTH] = hwm_q[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
            fire_overflow   <= '0;
            fire_underflow  <= '0;
            fire_push_pop   <= '0;
            fire_not_empty  <= '0;
            err_sticky      <= '0;
            first_err_valid <= 1'b0;
            first_err_chan  <= '0;
            first_err_code  <= '0;
        end else if (!enable) begin
            fire_overflow  <= '0;
            fire_underflow <= '0;
            fire_push_pop  <= '0;
            fire_not_empty <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_next[i];
            fire_overflow  <= ev_ov;
            fire_underflow <= ev_un;
            fire_push_pop  <= ev_pp;
            fire_not_empty <= ev_ne;
            err_sticky     <= (clear_err ? '0 : err_sticky) | ev_any;
            // A clear reopens the capture, so an error in the same cycle is recorded.
            if (clear_err || !first_err_valid) begin
                first_err_valid <= sel_any;
                first_err_chan  <= sel_chan;
                first_err_code  <= sel_code;
            end
        end
    end

    always_comb begin
        cnt   = '0;
        full  = '0;
        empty = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
            full[i]  = (cnt_q[i] == CNT_WIDTH'(DEPTH));
            empty[i] = (cnt_q[i] == '0);
        end
    end

endmodule
